// File: rtl/axis_engine_arbiter_if.sv
// rtl/axis_engine_arbiter_if.sv - AXI-4 Stream bundle used on every arbiter stream port
// master drives payload and tvalid; slave drives tready.
interface axis_engine_arbiter_if #(
  parameter int W = 32
);
  logic [W-1:0]   tdata;
  logic [W/8-1:0] tstrb;
  logic           tvalid;
  logic           tlast;
  logic           tready;

  modport master (output tdata, tstrb, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_engine_arbiter.sv
// rtl/axis_engine_arbiter.sv - packet round-robin arbiter sharing one ConvEngine FIFO
// One packet in flight: forward input from the owner, route the result back, then release.
module axis_engine_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int PACKET_LENGTH      = 256,
  parameter int CNT_W              = $clog2(PACKET_LENGTH) + 1
) (
  input  logic                        s00_axis_aclk,
  input  logic                        reset,
  axis_engine_arbiter_if.slave        s00_axis,
  axis_engine_arbiter_if.slave        s01_axis,
  axis_engine_arbiter_if.master       m00_axis,
  axis_engine_arbiter_if.slave        r_axis,
  axis_engine_arbiter_if.master       m10_axis,
  axis_engine_arbiter_if.master       m11_axis,
  output logic                        busy,
  output logic                        owner,
  output logic                        trunc_err,
  output logic [15:0]                 pkt_count
);

  localparam int SW = C_AXIS_TDATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACKET_LENGTH - 1);

  typedef enum logic [1:0] {IDLE, FWD, DROP, WAIT_RET} state_t;

  state_t                  state_q;
  logic                    owner_q;
  logic                    last_grant_q;
  logic                    ret_done_q;
  logic                    trunc_err_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [15:0]             pkt_count_q;

  logic [C_AXIS_TDATA_WIDTH-1:0] src_tdata;
  logic [SW-1:0]           src_tstrb;
  logic                    src_tvalid;
  logic                    src_tlast;
  logic                    src_tready;
  logic                    in_fwd;
  logic                    in_drop;
  logic                    ret_path;
  logic                    forced_last;
  logic                    m00_hs;
  logic                    src_hs;
  logic                    ret_sink_ready;
  logic                    ret_last_hs;
  logic                    grant_idx;

  assign src_tdata  = owner_q ? s01_axis.tdata  : s00_axis.tdata;
  assign src_tstrb  = owner_q ? s01_axis.tstrb  : s00_axis.tstrb;
  assign src_tvalid = owner_q ? s01_axis.tvalid : s00_axis.tvalid;
  assign src_tlast  = owner_q ? s01_axis.tlast  : s00_axis.tlast;

  assign in_fwd      = (state_q == FWD);
  assign in_drop     = (state_q == DROP);
  assign ret_path    = (state_q != IDLE);
  assign forced_last = (cnt_q == LAST_IDX);

  assign m00_axis.tvalid = in_fwd & src_tvalid;
  assign m00_axis.tdata  = src_tdata;
  assign m00_axis.tstrb  = src_tstrb;
  assign m00_axis.tlast  = in_fwd & (src_tlast | forced_last);

  // DROP swallows the tail of an over-long packet so the requester can finish it.
  assign src_tready      = (in_fwd & m00_axis.tready) | in_drop;
  assign s00_axis.tready = src_tready & ~owner_q;
  assign s01_axis.tready = src_tready & owner_q;

  assign m00_hs = m00_axis.tvalid & m00_axis.tready;
  assign src_hs = src_tvalid & src_tready;

  assign m10_axis.tdata  = r_axis.tdata;
  assign m10_axis.tstrb  = r_axis.tstrb;
  assign m10_axis.tlast  = r_axis.tlast;
  assign m10_axis.tvalid = ret_path & ~owner_q & r_axis.tvalid;
  assign m11_axis.tdata  = r_axis.tdata;
  assign m11_axis.tstrb  = r_axis.tstrb;
  assign m11_axis.tlast  = r_axis.tlast;
  assign m11_axis.tvalid = ret_path & owner_q & r_axis.tvalid;

  assign ret_sink_ready = owner_q ? m11_axis.tready : m10_axis.tready;
  assign r_axis.tready  = ret_path & ret_sink_ready;
  assign ret_last_hs    = r_axis.tvalid & r_axis.tready & r_axis.tlast;

  // On a tie the requester that did not win last time gets the engine.
  assign grant_idx = (s00_axis.tvalid & s01_axis.tvalid) ? ~last_grant_q : s01_axis.tvalid;

  always_ff @(posedge s00_axis_aclk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ret_done_q   <= 1'b0;
      trunc_err_q  <= 1'b0;
      cnt_q        <= '0;
      pkt_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s00_axis.tvalid | s01_axis.tvalid) begin
            owner_q      <= grant_idx;
            last_grant_q <= grant_idx;
            cnt_q        <= '0;
            ret_done_q   <= 1'b0;
            state_q      <= FWD;
          end
        end
        FWD: begin
          if (ret_last_hs) ret_done_q <= 1'b1;
          if (m00_hs) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (src_tlast) begin
              state_q <= WAIT_RET;
            end else if (forced_last) begin
              trunc_err_q <= 1'b1;
              state_q     <= DROP;
            end
          end
        end
        DROP: begin
          if (ret_last_hs) ret_done_q <= 1'b1;
          if (src_hs & src_tlast) state_q <= WAIT_RET;
        end
        WAIT_RET: begin
          if (ret_done_q | ret_last_hs) begin
            pkt_count_q <= pkt_count_q + 16'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;
  assign trunc_err = trunc_err_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axis_engine_arbiter.sv
// tb/tb_axis_engine_arbiter.sv - bench for axis_engine_arbiter
// Grant table, directed truncation/reset sequences, then random traffic against a trip-level model.
module tb_axis_engine_arbiter;
  localparam int W  = 32;
  localparam int PL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy, owner, trunc_err;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  axis_engine_arbiter_if #(.W(W)) s00_if ();
  axis_engine_arbiter_if #(.W(W)) s01_if ();
  axis_engine_arbiter_if #(.W(W)) m00_if ();
  axis_engine_arbiter_if #(.W(W)) r_if ();
  axis_engine_arbiter_if #(.W(W)) m10_if ();
  axis_engine_arbiter_if #(.W(W)) m11_if ();

  axis_engine_arbiter #(
    .C_AXIS_TDATA_WIDTH(W),
    .PACKET_LENGTH(PL)
  ) dut (
    .s00_axis_aclk(clk),
    .reset(reset),
    .s00_axis(s00_if),
    .s01_axis(s01_if),
    .m00_axis(m00_if),
    .r_axis(r_if),
    .m10_axis(m10_if),
    .m11_axis(m11_if),
    .busy(busy),
    .owner(owner),
    .trunc_err(trunc_err),
    .pkt_count(pkt_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s00_if.tvalid = 0; s00_if.tlast = 0; s00_if.tdata = '0; s00_if.tstrb = '1;
    s01_if.tvalid = 0; s01_if.tlast = 0; s01_if.tdata = '0; s01_if.tstrb = '1;
    r_if.tvalid   = 0; r_if.tlast   = 0; r_if.tdata   = '0; r_if.tstrb   = '1;
    m00_if.tready = 0; m10_if.tready = 0; m11_if.tready = 0;
  endtask

  typedef struct {
    bit v0;
    bit v1;
    bit exp_owner;
  } grant_vec_t;

  grant_vec_t tbl[8];

  // Trip-level reference model state for the random phase.
  bit          bm, om, lgm, in_done, rdone, trm;
  int          idx;
  logic [15:0] pcm;
  bit          has[2];
  int          len[2], pos[2];
  logic [31:0] base[2];
  int          rlen, rpos;
  logic [31:0] rbase;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 1, 0}; tbl[1] = '{1, 1, 1}; tbl[2] = '{1, 0, 0}; tbl[3] = '{1, 0, 0};
    tbl[4] = '{0, 1, 1}; tbl[5] = '{1, 1, 0}; tbl[6] = '{0, 1, 1}; tbl[7] = '{1, 1, 0};

    idle_inputs();
    reset = 1;
    repeat (3) step();
    reset = 0;
    @(negedge clk);
    chk1("rst_busy", busy, 0);
    chk1("rst_owner", owner, 0);
    chk1("rst_trunc", trunc_err, 0);
    chk32("rst_pkt", 32'(pkt_count), 0);
    chk1("rst_s00_rdy", s00_if.tready, 0);
    chk1("rst_s01_rdy", s01_if.tready, 0);
    chk1("rst_m00_vld", m00_if.tvalid, 0);
    chk1("rst_r_rdy", r_if.tready, 0);
    chk1("rst_m10_vld", m10_if.tvalid, 0);
    chk1("rst_m11_vld", m11_if.tvalid, 0);
    step();

    // Grant table: one-word packets, one-word results.
    for (int i = 0; i < 8; i++) begin
      s00_if.tvalid = tbl[i].v0; s00_if.tlast = 1; s00_if.tdata = 32'h10 + 32'(i);
      s01_if.tvalid = tbl[i].v1; s01_if.tlast = 1; s01_if.tdata = 32'h20 + 32'(i);
      m00_if.tready = 1; m10_if.tready = 1; m11_if.tready = 1;
      @(negedge clk);
      chk1("tbl_idle_rdy0", s00_if.tready, 0);
      chk1("tbl_idle_rdy1", s01_if.tready, 0);
      chk1("tbl_idle_m00v", m00_if.tvalid, 0);
      step();
      @(negedge clk);
      chk1("tbl_owner", owner, tbl[i].exp_owner);
      chk1("tbl_busy", busy, 1);
      chk32("tbl_m00_data", m00_if.tdata, tbl[i].exp_owner ? 32'h20 + 32'(i) : 32'h10 + 32'(i));
      chk1("tbl_m00_last", m00_if.tlast, 1);
      chk1("tbl_other_rdy", tbl[i].exp_owner ? s00_if.tready : s01_if.tready, 0);
      step();
      s00_if.tvalid = 0; s01_if.tvalid = 0;
      r_if.tvalid = 1; r_if.tlast = 1; r_if.tdata = 32'h300 + 32'(i);
      @(negedge clk);
      chk1("tbl_other_rdy_wait", tbl[i].exp_owner ? s00_if.tready : s01_if.tready, 0);
      chk1("tbl_ret_vld", tbl[i].exp_owner ? m11_if.tvalid : m10_if.tvalid, 1);
      chk1("tbl_ret_other", tbl[i].exp_owner ? m10_if.tvalid : m11_if.tvalid, 0);
      chk32("tbl_ret_data", tbl[i].exp_owner ? m11_if.tdata : m10_if.tdata, 32'h300 + 32'(i));
      step();
      r_if.tvalid = 0;
      @(negedge clk);
      chk1("tbl_done_busy", busy, 0);
      chk32("tbl_pkt", 32'(pkt_count), 32'(i + 1));
      step();
    end

    // Truncation: requester 1 sends PL+2 words.
    for (int k = 0; k < PL + 2; k++) begin
      s01_if.tvalid = 1; s01_if.tdata = 32'h100 + 32'(k); s01_if.tlast = (k == PL + 1);
      if (k == 0) begin
        @(negedge clk);
        chk1("tr_grant_rdy", s01_if.tready, 0);
        chk1("tr_trunc_before", trunc_err, 0);
        step();
      end
      @(negedge clk);
      chk1("tr_src_rdy", s01_if.tready, 1);
      chk1("tr_m00_vld", m00_if.tvalid, k < PL);
      if (k < PL) begin
        chk32("tr_m00_data", m00_if.tdata, 32'h100 + 32'(k));
        chk1("tr_m00_last", m00_if.tlast, k == PL - 1);
      end else begin
        chk1("tr_trunc_set", trunc_err, 1);
      end
      step();
    end
    s01_if.tvalid = 0;
    r_if.tvalid = 1; r_if.tlast = 1; r_if.tdata = 32'hABC;
    @(negedge clk);
    chk1("tr_m11_vld", m11_if.tvalid, 1);
    chk1("tr_m10_vld", m10_if.tvalid, 0);
    chk32("tr_m11_data", m11_if.tdata, 32'hABC);
    step();
    r_if.tvalid = 0;
    @(negedge clk);
    chk1("tr_busy", busy, 0);
    chk1("tr_trunc_sticky", trunc_err, 1);
    chk32("tr_pkt", 32'(pkt_count), 9);
    step();

    // Reset after three of six words forwarded.
    s00_if.tvalid = 1; s00_if.tlast = 0; s00_if.tdata = 32'h40;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk32("rm_m00_data", m00_if.tdata, 32'h40 + 32'(k));
      step();
      s00_if.tdata = 32'h40 + 32'(k + 1);
    end
    reset = 1;
    step();
    reset = 0;
    s00_if.tvalid = 0;
    @(negedge clk);
    chk1("rm_busy", busy, 0);
    chk1("rm_owner", owner, 0);
    chk32("rm_pkt", 32'(pkt_count), 0);
    chk1("rm_trunc", trunc_err, 0);
    chk1("rm_s00_rdy", s00_if.tready, 0);
    chk1("rm_m00_vld", m00_if.tvalid, 0);
    chk1("rm_r_rdy", r_if.tready, 0);
    step();
    s00_if.tvalid = 1; s00_if.tlast = 1; s00_if.tdata = 32'h50;
    step();
    @(negedge clk);
    chk1("rm_regrant_owner", owner, 0);
    chk32("rm_regrant_data", m00_if.tdata, 32'h50);
    step();
    s00_if.tvalid = 0;
    r_if.tvalid = 1; r_if.tlast = 1; r_if.tdata = 32'h51;
    @(negedge clk);
    chk1("rm_ret_vld", m10_if.tvalid, 1);
    step();
    r_if.tvalid = 0;
    @(negedge clk);
    chk32("rm_pkt_after", 32'(pkt_count), 1);
    step();

    // Random traffic against the trip-level model.
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    bm = 0; om = 0; lgm = 1; in_done = 0; rdone = 0; trm = 0; idx = 0; pcm = '0;
    has[0] = 0; has[1] = 0; rlen = 0; rpos = 0; rbase = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit   sv, slast, fwd_m, drop_m, src_rdy, sink_rdy, rr, end_now, rhs;
      bit   hs[2];
      logic [31:0] sword;
      for (int i = 0; i < 2; i++) begin
        if (!has[i] && $urandom_range(0, 3) == 0) begin
          has[i] = 1; len[i] = $urandom_range(1, PL + 3); pos[i] = 0; base[i] = $urandom;
        end
      end
      s00_if.tvalid = has[0]; s00_if.tdata = base[0] + 32'(pos[0]); s00_if.tlast = (pos[0] == len[0] - 1);
      s01_if.tvalid = has[1]; s01_if.tdata = base[1] + 32'(pos[1]); s01_if.tlast = (pos[1] == len[1] - 1);
      r_if.tvalid = bm && (rpos < rlen); r_if.tdata = rbase + 32'(rpos); r_if.tlast = (rpos == rlen - 1);
      m00_if.tready = 1'($urandom_range(0, 1));
      m10_if.tready = ($urandom_range(0, 3) != 0);
      m11_if.tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      sv      = om ? s01_if.tvalid : s00_if.tvalid;
      slast   = om ? s01_if.tlast  : s00_if.tlast;
      sword   = om ? s01_if.tdata  : s00_if.tdata;
      fwd_m   = bm && !in_done && idx < PL;
      drop_m  = bm && !in_done && idx >= PL;
      src_rdy = fwd_m ? m00_if.tready : drop_m;
      sink_rdy = om ? m11_if.tready : m10_if.tready;
      rr      = bm && sink_rdy;
      chk1("rnd_busy", busy, bm);
      if (bm) chk1("rnd_owner", owner, om);
      chk1("rnd_s00_rdy", s00_if.tready, !om && src_rdy);
      chk1("rnd_s01_rdy", s01_if.tready, om && src_rdy);
      chk1("rnd_m00_vld", m00_if.tvalid, fwd_m && sv);
      if (fwd_m && sv) begin
        chk32("rnd_m00_data", m00_if.tdata, sword);
        chk1("rnd_m00_last", m00_if.tlast, slast || idx == PL - 1);
      end
      chk1("rnd_r_rdy", r_if.tready, rr);
      chk1("rnd_m10_vld", m10_if.tvalid, bm && !om && r_if.tvalid);
      chk1("rnd_m11_vld", m11_if.tvalid, bm && om && r_if.tvalid);
      if (bm && r_if.tvalid) begin
        chk32("rnd_ret_data", om ? m11_if.tdata : m10_if.tdata, r_if.tdata);
        chk1("rnd_ret_last", om ? m11_if.tlast : m10_if.tlast, r_if.tlast);
      end
      chk32("rnd_pkt", 32'(pkt_count), 32'(pcm));
      chk1("rnd_trunc", trunc_err, trm);
      hs[0] = s00_if.tvalid && !om && src_rdy;
      hs[1] = s01_if.tvalid && om && src_rdy;
      rhs   = r_if.tvalid && rr;
      if (!bm) begin
        if (s00_if.tvalid || s01_if.tvalid) begin
          om = (s00_if.tvalid && s01_if.tvalid) ? !lgm : s01_if.tvalid;
          lgm = om; bm = 1; idx = 0; in_done = 0; rdone = 0;
          rlen = $urandom_range(1, 4); rpos = 0; rbase = $urandom;
        end
      end else begin
        end_now = in_done && (rdone || (rhs && r_if.tlast));
        if (hs[om]) begin
          if (fwd_m && idx == PL - 1 && !slast) trm = 1;
          idx++;
          if (slast) in_done = 1;
        end
        if (rhs && r_if.tlast) rdone = 1;
        if (rhs) rpos++;
        if (end_now) begin
          bm = 0;
          pcm = pcm + 16'd1;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (hs[i]) begin
          if (pos[i] == len[i] - 1) has[i] = 0;
          else pos[i]++;
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
